// File: rtl/correlacion_pkg.sv
// Shared state encoding and width helpers for the adaptive correlation detector.
package correlacion_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        PRIME   = 2'd1,
        TRACK   = 2'd2,
        HOLDOFF = 2'd3
    } corr_state_e;

    // A match count spans 0..L inclusive, so it needs one bit beyond $clog2(L).
    function automatic int corr_width(input int samples, input int osf);
        return $clog2(samples * osf) + 1;
    endfunction

    function automatic int sum_width(input int samples, input int osf, input int n_avg);
        return corr_width(samples, osf) + $clog2(n_avg);
    endfunction

    // One counter serves accepted bits (FILL/HOLDOFF) and priming pulses (PRIME).
    function automatic int cnt_width(input int l, input int n_avg);
        return (l > n_avg) ? $clog2(l) : $clog2(n_avg);
    endfunction

endpackage

// File: rtl/contador_coincidencias.sv
// Combinational XNOR + popcount of the sample window against the reference pattern.
module contador_coincidencias
    import correlacion_pkg::*;
#(
    parameter  int SAMPLES = 2,
    parameter  int OSF     = 8,
    localparam int L       = SAMPLES * OSF,
    localparam int CW      = corr_width(SAMPLES, OSF)
) (
    input  logic [L-1:0]  window,
    input  logic [L-1:0]  pattern,
    output logic [CW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < L; i++) begin
            count = count + CW'(~(window[i] ^ pattern[i]));
        end
    end

endmodule

// File: rtl/correlador_adaptativo.sv
// Streaming correlator with moving-average threshold detection.
// Define CORR_HOLDOFF_EN to limit detections to one per L accepted bits.
module correlador_adaptativo
    import correlacion_pkg::*;
#(
    parameter  int SAMPLES = 2,
    parameter  int OSF     = 8,
    parameter  int N_AVG   = 4,
    localparam int L       = SAMPLES * OSF,
    localparam int CW      = corr_width(SAMPLES, OSF)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [L-1:0]  pattern,
    input  logic [CW-1:0] margin,
    input  logic          bit_in,
    input  logic          bit_valid,
    output logic [CW-1:0] corr_value,
    output logic          corr_valid,
    output logic [CW-1:0] avg_value,
    output logic          detect,
    output corr_state_e   state_dbg
);

    localparam int SW   = sum_width(SAMPLES, OSF, N_AVG);
    localparam int AW   = $clog2(N_AVG);
    localparam int CNTW = cnt_width(L, N_AVG);

    corr_state_e     state;
    logic [L-1:0]    window;
    logic [CW-1:0]   match_count;
    logic [CW-1:0]   hist [N_AVG];
    logic [AW-1:0]   wr_ptr;
    logic [SW-1:0]   sum;
    logic [SW-1:0]   sum_next;
    logic [CNTW-1:0] cnt;
    logic            pend;
    logic            fill_done;
    logic [CW:0]     threshold;
    logic            hit;

    contador_coincidencias #(
        .SAMPLES (SAMPLES),
        .OSF     (OSF)
    ) u_contador (
        .window  (window),
        .pattern (pattern),
        .count   (match_count)
    );

    assign fill_done = (state == FILL) && bit_valid && (cnt == CNTW'(L - 1));
    assign sum_next  = sum + SW'(corr_value) - SW'(hist[wr_ptr]);
    // avg_value still holds the average before corr_value joins it.
    assign threshold = {1'b0, avg_value} + {1'b0, margin};
    assign hit       = corr_valid && (state == TRACK) && ({1'b0, corr_value} > threshold);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FILL;
            window     <= '0;
            wr_ptr     <= '0;
            sum        <= '0;
            cnt        <= '0;
            pend       <= 1'b0;
            corr_value <= '0;
            corr_valid <= 1'b0;
            avg_value  <= '0;
            detect     <= 1'b0;
            for (int i = 0; i < N_AVG; i++) begin
                hist[i] <= '0;
            end
        end else if (enable) begin
            if (bit_valid) begin
                window <= {window[L-2:0], bit_in};
            end
            // The L-th fill bit already yields a valid correlation.
            pend       <= bit_valid && ((state != FILL) || fill_done);
            corr_valid <= pend;
            if (pend) begin
                corr_value <= match_count;
            end
            detect <= hit;
            if (corr_valid) begin
                hist[wr_ptr] <= corr_value;
                wr_ptr       <= wr_ptr + AW'(1);
                sum          <= sum_next;
                avg_value    <= sum_next[SW-1:AW];
            end
            case (state)
                FILL: begin
                    if (bit_valid) begin
                        if (fill_done) begin
                            state <= PRIME;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNTW'(1);
                        end
                    end
                end
                PRIME: begin
                    if (corr_valid) begin
                        if (cnt == CNTW'(N_AVG - 1)) begin
                            state <= TRACK;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNTW'(1);
                        end
                    end
                end
                TRACK: begin
`ifdef CORR_HOLDOFF_EN
                    if (hit) begin
                        state <= HOLDOFF;
                        cnt   <= '0;
                    end
`endif
                end
                HOLDOFF: begin
`ifdef CORR_HOLDOFF_EN
                    if (bit_valid) begin
                        if (cnt == CNTW'(L - 1)) begin
                            state <= TRACK;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNTW'(1);
                        end
                    end
`else
                    state <= TRACK;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_correlador_adaptativo.sv
// Directed plus random bench for correlador_adaptativo with a cycle-level reference model.
module tb_correlador_adaptativo;
    import correlacion_pkg::*;

    localparam int SAMPLES = 2;
    localparam int OSF     = 8;
    localparam int N_AVG   = 4;
    localparam int L       = SAMPLES * OSF;
    localparam int CW      = $clog2(L) + 1;
    localparam int EW      = 2 * CW + 1;
`ifdef CORR_HOLDOFF_EN
    localparam bit HOLDOFF_ON = 1'b1;
`else
    localparam bit HOLDOFF_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable;
    logic [L-1:0]  pattern;
    logic [CW-1:0] margin;
    logic          bit_in;
    logic          bit_valid;
    logic [CW-1:0] corr_value;
    logic          corr_valid;
    logic [CW-1:0] avg_value;
    logic          detect;
    corr_state_e   state_dbg;

    correlador_adaptativo #(
        .SAMPLES (SAMPLES),
        .OSF     (OSF),
        .N_AVG   (N_AVG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pattern    (pattern),
        .margin     (margin),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .corr_value (corr_value),
        .corr_valid (corr_valid),
        .avg_value  (avg_value),
        .detect     (detect),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    // Scoreboard entries are {corr_value, detect, avg_value} of one correlation.
    logic [EW-1:0] exp_q[$];
    int n_tests   = 0;
    int n_fail    = 0;
    int det_count = 0;

    // Reference model state, advanced once per rising edge.
    logic [L-1:0] m_win;
    int           m_hist[$];
    corr_state_e  m_state;
    int           m_cnt;
    bit           m_pend;
    bit           m_cv;
    int           m_cval;
    int           m_avg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int popmatch(input logic [L-1:0] w, input logic [L-1:0] p);
        int n = 0;
        for (int i = 0; i < L; i++) begin
            if (w[i] == p[i]) n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        m_win   = '0;
        m_hist.delete();
        m_state = FILL;
        m_cnt   = 0;
        m_pend  = 1'b0;
        m_cv    = 1'b0;
        m_cval  = 0;
        m_avg   = 0;
    endtask

    task automatic model_edge(input bit en, input bit v, input bit b);
        corr_state_e s0;
        bit          n_pend;
        bit          det;
        int          total;
        if (!en) return;
        s0     = m_state;
        n_pend = v && ((s0 != FILL) || (m_cnt == L - 1));
        det    = 1'b0;
        if (m_cv) begin
            det = (s0 == TRACK) && (m_cval > m_avg + int'(margin));
            m_hist.push_back(m_cval);
            if (m_hist.size() > N_AVG) void'(m_hist.pop_front());
            total = 0;
            foreach (m_hist[i]) total += m_hist[i];
            m_avg = total / N_AVG;
            exp_q.push_back({CW'(m_cval), det, CW'(m_avg)});
        end
        case (s0)
            FILL: if (v) begin
                if (m_cnt == L - 1) begin m_state = PRIME; m_cnt = 0; end
                else m_cnt++;
            end
            PRIME: if (m_cv) begin
                m_cnt++;
                if (m_cnt == N_AVG) begin m_state = TRACK; m_cnt = 0; end
            end
            TRACK: if (det && HOLDOFF_ON) begin m_state = HOLDOFF; m_cnt = 0; end
            HOLDOFF: if (v) begin
                m_cnt++;
                if (m_cnt == L) begin m_state = TRACK; m_cnt = 0; end
            end
        endcase
        if (m_pend) m_cval = popmatch(m_win, pattern);
        m_cv   = m_pend;
        m_pend = n_pend;
        if (v) m_win = {m_win[L-2:0], b};
    endtask

    task automatic step(input bit en, input bit v, input bit b);
        enable    = en;
        bit_valid = v;
        bit_in    = b;
        @(posedge clk);
        model_edge(en, v, b);
        #1;
    endtask

    task automatic send(input bit b);
        step(1'b1, 1'b1, b);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_corr_valid", corr_valid, 0);
        check("rst_corr_value", corr_value, 0);
        check("rst_avg", avg_value, 0);
        check("rst_detect", detect, 0);
        check("rst_state", state_dbg, FILL);
        exp_q.delete();
        model_reset();
        enable    = 1'b0;
        bit_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic prime(input logic [CW-1:0] m);
        do_reset();
        pattern = 16'h00FF;
        margin  = m;
        repeat (L + N_AVG - 1) send(1'b1);
        repeat (3) idle();
    endtask

    // Scoreboard: a correlation seen last cycle is completed by this cycle's detect/avg.
    logic          prev_cv = 1'b0;
    logic [CW-1:0] prev_cval;
    logic [EW-1:0] e;
    always @(negedge clk) begin
        if (reset) begin
            prev_cv = 1'b0;
        end else begin
            if (prev_cv) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_corr", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_corr", prev_cval, e[EW-1 -: CW]);
                    check("sb_detect", detect, e[CW]);
                    check("sb_avg", avg_value, e[CW-1:0]);
                end
            end else begin
                check("idle_detect", detect, 0);
            end
            if (detect) det_count++;
            prev_cv   = corr_valid;
            prev_cval = corr_value;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        enable    = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        pattern   = '0;
        margin    = '0;
        #2;
        do_reset();

        // Fill boundary and all-ones stream.
        pattern   = 16'hFFFF;
        margin    = '0;
        det_count = 0;
        repeat (L - 1) send(1'b1);
        idle();
        check("fill15_valid", corr_valid, 0);
        check("fill15_state", state_dbg, FILL);
        send(1'b1);
        idle();
        check("fill16_valid", corr_valid, 1);
        check("fill16_value", corr_value, 16);
        repeat (11) send(1'b1);
        repeat (3) idle();
        check("ones_avg", avg_value, 16);
        check("ones_state", state_dbg, TRACK);
        check("ones_no_detect", det_count, 0);

        // Score 12 against average 8 with margin 3.
        prime(5'd3);
        check("prime_avg", avg_value, 8);
        check("prime_state", state_dbg, TRACK);
        pattern = 16'h0FFF;
        send(1'b1);
        idle();
        check("hit12_corr", corr_value, 12);
        check("hit12_detect_k1", detect, 0);
        idle();
        check("hit12_detect_k2", detect, 1);
        check("hit12_state", state_dbg, HOLDOFF_ON ? HOLDOFF : TRACK);

        // Score 11 sits exactly at the threshold.
        prime(5'd3);
        pattern = 16'h07FF;
        send(1'b1);
        idle();
        idle();
        check("hit11_detect", detect, 0);
        check("hit11_avg", avg_value, 8);

        // Burst of matching windows, then re-arm after the average settles.
        prime(5'd0);
        pattern   = 16'hFFFF;
        det_count = 0;
        repeat (24) send(1'b1);
        repeat (3) idle();
        check("burst_detects", det_count, HOLDOFF_ON ? 1 : 4);
        pattern = 16'h00FF;
        repeat (8) send(1'b1);
        repeat (3) idle();
        pattern = 16'hFFFF;
        send(1'b1);
        repeat (3) idle();
        check("rearm_detects", det_count, HOLDOFF_ON ? 2 : 5);

        // Enable low with valid zeros: nothing may move.
        repeat (10) step(1'b0, 1'b1, 1'b0);
        check("freeze_avg", avg_value, 10);
        check("freeze_corr", corr_value, 16);
        check("freeze_valid", corr_valid, 0);
        check("freeze_detect", detect, 0);
        check("freeze_state", state_dbg, HOLDOFF_ON ? HOLDOFF : TRACK);
        send(1'b1);
        check("resume_k0_valid", corr_valid, 0);
        idle();
        check("resume_k1_valid", corr_valid, 1);
        check("resume_k1_corr", corr_value, 16);

        // Asynchronous reset while tracking, then a full refill.
        repeat (20) send(1'b1);
        check("pre_reset_state", state_dbg, TRACK);
        do_reset();
        pattern = 16'hFFFF;
        repeat (L - 1) send(1'b1);
        idle();
        check("refill15_valid", corr_valid, 0);
        send(1'b1);
        idle();
        check("refill16_valid", corr_valid, 1);

        // Random bits, gaps and patterns against the model.
        do_reset();
        margin = CW'($urandom_range(0, 3));
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) pattern = L'($urandom);
            step(1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        repeat (4) idle();
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/correlador_adaptativo.md
# correlador_adaptativo

Streaming correlation detector for the oversampled receive path: shifts in one oversampled bit per valid strobe, correlates the last SAMPLES*OSF bits against a programmable pattern, and tracks a moving average of the last N_AVG correlation values. It flags a detection when the current correlation exceeds that average by a programmable margin. It is the clocked, parametrised successor of the combinational correlation/compare chain and feeds the frame-sync logic.

## Interface
- SAMPLES, 2, symbols per correlation window
- OSF, 8, oversampling factor; window length L = SAMPLES*OSF
- N_AVG, 4, moving-average depth; power of two, ≥2
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- Enable  in  1  high: block advances; low: all state frozen, BitValid ignored
- Pattern  in  L  reference pattern; bit 0 compares with the newest bit; sampled every cycle
- Margin  in  CW  detection margin, unsigned; CW = $clog2(L)+1
- BitIn  in  1  incoming oversampled bit
- BitValid  in  1  BitIn qualifier; one bit accepted per cycle when high and Enable is high
- CorrValue  out  CW  registered match count, 0..L
- CorrValid  out  1  one-cycle pulse when CorrValue updates
- AvgValue  out  CW  floor(sum of last N_AVG CorrValue) / N_AVG
- Detect  out  1  one-cycle detection pulse

## Operation
- Window: L-bit shift register. An accepted bit shifts in at bit 0.
- Correlation: CorrValue = popcount(~(Window ^ Pattern)), registered.
- Average: N_AVG-entry circular buffer plus a running sum of width CW+$clog2(N_AVG). Each CorrValid adds the new value and subtracts the evicted one. AvgValue = sum >> $clog2(N_AVG).
- Compare: evaluated at CW+1 bits with no overflow. The condition is CorrValue > AvgValue + Margin, where AvgValue is the value before the current CorrValue is included.
- Accepted-bit counter: used for the FILL and HOLDOFF states.
- States:
  - FILL: entered from reset. Counts L accepted bits. CorrValid is suppressed. Moves to PRIME when the L-th bit is accepted.
  - PRIME: CorrValues enter the buffer and Detect is suppressed. Moves to TRACK after N_AVG CorrValid pulses.
  - TRACK: Detect fires on the compare condition. On a detect, moves to HOLDOFF (macro-dependent, see Configuration).
  - HOLDOFF: the average keeps updating and Detect is suppressed. Returns to TRACK after L further accepted bits.
- Pattern change mid-stream: takes effect on the next correlation. No state reset.
- Enable low while BitValid is high: the bit is dropped and nothing counts.

## Timing
- All outputs reset to 0. State resets to FILL; buffer, sum and counters reset to 0.
- Accept edge k → CorrValid/CorrValue at edge k+1 → Detect and updated AvgValue at edge k+2.
- Fixed latency of 2 clocks. One bit per cycle is sustained with no stalls.
- Back-to-back accepts produce back-to-back CorrValid pulses. The running sum updates every cycle without hazard.
- Reset asserted mid-stream: outputs drop to 0 asynchronously. The block restarts in FILL and needs L bits again.
- Margin = 0: the strict > condition still applies, so equality never detects.

## Configuration
- CORR_HOLDOFF_EN defined: the HOLDOFF state is present. At most one Detect occurs per L accepted bits.
- CORR_HOLDOFF_EN undefined: there is no HOLDOFF state. TRACK detects on every qualifying correlation, so consecutive detects are allowed.

## Structure
- Package correlacion_pkg holds:
  - the state enum (FILL, PRIME, TRACK, HOLDOFF);
  - width functions: CW, sum width, counter width.
- Sub-module contador_coincidencias: combinational XNOR plus popcount over L bits, parametrised by SAMPLES and OSF.

## Test plan
- Reset, then 15 bits with L=16 → CorrValid stays 0. The 16th bit → CorrValid pulses at +1 clock.
- Pattern=16'hFFFF, stream of all 1s → CorrValue=16. After priming, AvgValue=16 and Detect never fires.
- Prime with N_AVG=4 windows at CorrValue=8, Margin=3, then a window scoring 12 → Detect pulses at k+2. Repeat with a score of 11 → no Detect.
- Repeated matching windows with CORR_HOLDOFF_EN defined → one Detect, then silence for 16 accepted bits. With the macro undefined → a Detect on each qualifying window.
- Enable low for 10 cycles with BitValid high → all outputs and state unchanged. On resume, latency is still 2.
- Reset pulse mid-TRACK → all outputs 0 at once. FILL requires 16 new bits before the next CorrValid.
